// File: rtl/if_fetch.sv
// RISC-V instruction-fetch stage: PC, credit-limited imem requests, instruction buffer to decode.
// Optional IF_PERF_CNT_EN adds delivered/flushed instruction counters.
module if_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic        o_inst_valid,
  output logic [31:0] o_inst,
  output logic [31:0] o_inst_pc,
`ifdef IF_PERF_CNT_EN
  output logic [31:0] o_fetch_cnt,
  output logic [31:0] o_flush_cnt,
`endif
  input  logic        i_inst_ready
);

  localparam int          AW     = $clog2(FIFO_DEPTH);
  localparam int          CW     = AW + 1;
  localparam logic [CW-1:0] C_ONE  = CW'(1);
  localparam logic [AW-1:0] PQ_ONE = AW'(1);
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic          r_active;
  logic [31:0]   r_pc;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_drop;
  logic [CW-1:0] r_fq_wr;
  logic [CW-1:0] r_fq_rd;
  logic [AW-1:0] r_pq_wr;
  logic [AW-1:0] r_pq_rd;
  logic [31:0]   r_fq_inst [FIFO_DEPTH];
  logic [31:0]   r_fq_pc   [FIFO_DEPTH];
  logic [31:0]   r_pq_pc   [FIFO_DEPTH];

  logic [CW-1:0] w_fq_count;
  logic          w_fq_empty;
  logic          w_fq_full;
  logic [CW:0]   w_occ;
  logic          w_req;
  logic          w_grant;
  logic          w_rv;
  logic          w_keep;
  logic          w_pop;
  logic          w_push;
  logic [CW-1:0] w_out_next;
  logic [AW-1:0] w_wr_idx;
  logic [AW-1:0] w_rd_idx;

  assign w_fq_count = r_fq_wr - r_fq_rd;
  assign w_fq_empty = (r_fq_wr == r_fq_rd);
  assign w_fq_full  = (w_fq_count == CW'(FIFO_DEPTH));
  assign w_wr_idx   = r_fq_wr[AW-1:0];
  assign w_rd_idx   = r_fq_rd[AW-1:0];

  // A head leaving this cycle frees its slot, so the credit counts it as gone;
  // this is what lets a 1-cycle memory sustain one instruction per cycle.
  assign w_pop   = !w_fq_empty && i_inst_ready && !i_redirect;
  assign w_occ   = {1'b0, r_outstanding} + {1'b0, w_fq_count} - {{CW{1'b0}}, w_pop};
  assign w_req   = r_active && !i_redirect && (w_occ < (CW+1)'(FIFO_DEPTH));
  assign w_grant = w_req && i_imem_gnt;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign w_rv       = i_imem_rvalid && (r_outstanding != '0);
  assign w_keep     = w_rv && !i_redirect && (r_drop == '0);
  assign w_push     = w_keep && (!w_fq_full || w_pop);
  assign w_out_next = r_outstanding + {{(CW-1){1'b0}}, w_grant} - {{(CW-1){1'b0}}, w_rv};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_active      <= 1'b0;
      r_pc          <= RESET_PC;
      r_outstanding <= '0;
      r_drop        <= '0;
      r_fq_wr       <= '0;
      r_fq_rd       <= '0;
      r_pq_wr       <= '0;
      r_pq_rd       <= '0;
    end else begin
      r_active      <= 1'b1;
      r_outstanding <= w_out_next;
      if (i_redirect) begin
        // Everything still in flight after this cycle belongs to the old path.
        r_pc    <= i_redirect_pc & 32'hFFFF_FFFC;
        r_drop  <= w_out_next;
        r_fq_wr <= '0;
        r_fq_rd <= '0;
        r_pq_wr <= '0;
        r_pq_rd <= '0;
      end else begin
        if (w_grant) begin
          r_pc    <= r_pc + 32'd4;
          r_pq_wr <= r_pq_wr + PQ_ONE;
        end
        if (w_rv) begin
          if (r_drop != '0) r_drop <= r_drop - C_ONE;
          else              r_pq_rd <= r_pq_rd + PQ_ONE;
        end
        if (w_push) r_fq_wr <= r_fq_wr + C_ONE;
        if (w_pop)  r_fq_rd <= r_fq_rd + C_ONE;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_grant) r_pq_pc[r_pq_wr] <= r_pc;
    if (w_push) begin
      r_fq_inst[w_wr_idx] <= i_imem_rdata;
      r_fq_pc[w_wr_idx]   <= r_pq_pc[r_pq_rd];
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fetch_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_pop) r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (w_rv && (i_redirect || (r_drop != '0))) r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign o_fetch_cnt = r_fetch_cnt;
  assign o_flush_cnt = r_flush_cnt;
`endif

  assign o_imem_req   = w_req;
  assign o_imem_addr  = r_pc;
  assign o_inst_valid = !w_fq_empty;
  assign o_inst       = w_fq_empty ? NOP   : r_fq_inst[w_rd_idx];
  assign o_inst_pc    = w_fq_empty ? 32'h0 : r_fq_pc[w_rd_idx];

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch with a latency-programmable memory model and an output scoreboard.
module tb_if_fetch;

  typedef struct { logic [31:0] pc; logic [31:0] inst; } exp_t;
  typedef struct { logic [31:0] data; int due; } mem_t;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        i_imem_gnt;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;
  logic        i_inst_ready;
  logic        o_imem_req,  u2_req;
  logic [31:0] o_imem_addr, u2_addr;
  logic        o_inst_valid, u2_valid;
  logic [31:0] o_inst, u2_inst;
  logic [31:0] o_inst_pc, u2_pc;
`ifdef IF_PERF_CNT_EN
  logic [31:0] o_fetch_cnt, o_flush_cnt, u2_fetch_cnt, u2_flush_cnt;
  int          exp_fetch, exp_flush;
`endif

  if_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) u_dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
    .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr), .i_imem_gnt(i_imem_gnt),
    .i_imem_rvalid(i_imem_rvalid), .i_imem_rdata(i_imem_rdata),
    .o_inst_valid(o_inst_valid), .o_inst(o_inst), .o_inst_pc(o_inst_pc),
`ifdef IF_PERF_CNT_EN
    .o_fetch_cnt(o_fetch_cnt), .o_flush_cnt(o_flush_cnt),
`endif
    .i_inst_ready(i_inst_ready)
  );

  if_fetch #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) u_dut_wrap (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
    .o_imem_req(u2_req), .o_imem_addr(u2_addr), .i_imem_gnt(i_imem_gnt),
    .i_imem_rvalid(i_imem_rvalid), .i_imem_rdata(i_imem_rdata),
    .o_inst_valid(u2_valid), .o_inst(u2_inst), .o_inst_pc(u2_pc),
`ifdef IF_PERF_CNT_EN
    .o_fetch_cnt(u2_fetch_cnt), .o_flush_cnt(u2_flush_cnt),
`endif
    .i_inst_ready(i_inst_ready)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int          n_tests, n_fail, cyc, lat, n_deliv;
  logic        gnt_en, rdy, redir;
  logic [31:0] redir_pc, model_pc;
  logic        obs_req, obs_valid, obs2_req, obs2_valid;
  logic [31:0] obs_addr, obs_pc, obs2_addr, obs2_pc, obs2_inst;
  logic [31:0] u2_exp [3];
  mem_t        memq [$];
  exp_t        sbq  [$];

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rst_n = 1'b0;
    i_redirect = 1'b0; i_redirect_pc = '0; i_imem_gnt = 1'b0;
    i_imem_rvalid = 1'b0; i_imem_rdata = '0; i_inst_ready = 1'b0;
    memq.delete(); sbq.delete();
    model_pc = 32'h0; n_deliv = 0; redir = 1'b0; gnt_en = 1'b1; rdy = 1'b1;
`ifdef IF_PERF_CNT_EN
    exp_fetch = 0; exp_flush = 0;
`endif
    #1;
    chk1("rst_req",   o_imem_req,   1'b0);
    chk ("rst_addr",  o_imem_addr,  32'h0);
    chk1("rst_valid", o_inst_valid, 1'b0);
    chk ("rst_inst",  o_inst,       32'h0000_0013);
    chk ("rst_pc",    o_inst_pc,    32'h0);
    chk ("rst_addr_wrap", u2_addr,  32'hFFFF_FFF8);
`ifdef IF_PERF_CNT_EN
    chk ("rst_fetch_cnt", o_fetch_cnt, 32'h0);
    chk ("rst_flush_cnt", o_flush_cnt, 32'h0);
`endif
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  // One clock: drive memory/handshake at the falling edge, then sample and score.
  task automatic cycle();
    mem_t m;
    exp_t e;
    @(negedge i_clk);
    i_imem_rvalid = 1'b0;
    i_imem_rdata  = '0;
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      i_imem_rvalid = 1'b1;
      i_imem_rdata  = memq[0].data;
    end
    i_imem_gnt = gnt_en; i_inst_ready = rdy;
    i_redirect = redir;  i_redirect_pc = redir_pc;
    #1;
    obs_req = o_imem_req; obs_addr = o_imem_addr; obs_valid = o_inst_valid; obs_pc = o_inst_pc;
    obs2_req = u2_req; obs2_addr = u2_addr; obs2_valid = u2_valid;
    obs2_pc = u2_pc; obs2_inst = u2_inst;
    if (i_imem_rvalid) void'(memq.pop_front());
    if (redir) begin
      chk1("req_low_on_redirect", o_imem_req, 1'b0);
`ifdef IF_PERF_CNT_EN
      exp_flush += memq.size() + (i_imem_rvalid ? 1 : 0);
`endif
      sbq.delete();
      model_pc = redir_pc & 32'hFFFF_FFFC;
    end else begin
      if (o_imem_req && i_imem_gnt) begin
        chk("fetch_addr", o_imem_addr, model_pc);
        m.data = mdata(model_pc); m.due = cyc + lat;
        memq.push_back(m);
        e.pc = model_pc; e.inst = mdata(model_pc);
        sbq.push_back(e);
        model_pc = model_pc + 32'd4;
      end
      if (o_inst_valid && i_inst_ready) begin
        n_deliv++;
`ifdef IF_PERF_CNT_EN
        exp_fetch++;
`endif
        chk1("sb_nonempty", sbq.size() != 0, 1'b1);
        if (sbq.size() != 0) begin
          e = sbq.pop_front();
          chk("inst_pc", o_inst_pc, e.pc);
          chk("inst",    o_inst,    e.inst);
        end
      end
    end
    cyc++;
  endtask

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0; lat = 1; n_deliv = 0;
    gnt_en = 1'b1; rdy = 1'b1; redir = 1'b0; redir_pc = '0; model_pc = '0;
    i_rst_n = 1'b0; i_redirect = 1'b0; i_redirect_pc = '0; i_imem_gnt = 1'b0;
    i_imem_rvalid = 1'b0; i_imem_rdata = '0; i_inst_ready = 1'b0;
    u2_exp[0] = 32'hFFFF_FFF8; u2_exp[1] = 32'hFFFF_FFFC; u2_exp[2] = 32'h0000_0000;

    // Streaming with a 1-cycle memory; the second instance checks PC wrap.
    do_reset(); lat = 1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (i < 3) begin
        chk1("wrap_req", obs2_req, 1'b1);
        chk ("wrap_addr", obs2_addr, u2_exp[i]);
      end
      if (i == 2) begin
        chk1("wrap_valid", obs2_valid, 1'b1);
        chk ("wrap_inst_pc", obs2_pc, 32'hFFFF_FFF8);
        chk ("wrap_inst", obs2_inst, mdata(32'h0));
      end
    end
    chk("stream_deliveries", n_deliv, 8);
`ifdef IF_PERF_CNT_EN
    chk("stream_fetch_cnt", o_fetch_cnt, exp_fetch);
    chk("stream_flush_cnt", o_flush_cnt, 32'h0);
    chk("wrap_fetch_cnt", u2_fetch_cnt, exp_fetch);
    chk("wrap_flush_cnt", u2_flush_cnt, 32'h0);
`endif

    // Back-pressure: buffer fills, fetch stalls at 8, then resumes without loss.
    do_reset(); lat = 1; rdy = 1'b0;
    for (int i = 0; i < 5; i++) cycle();
    chk1("stall_req",   obs_req,   1'b0);
    chk ("stall_addr",  obs_addr,  32'h8);
    chk1("stall_valid", obs_valid, 1'b1);
    chk ("stall_pc",    obs_pc,    32'h0);
    rdy = 1'b1; n_deliv = 0;
    for (int i = 0; i < 8; i++) cycle();
    chk("resume_deliveries", n_deliv, 8);

    // Grant withheld: request and address must hold.
    do_reset(); lat = 1; gnt_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk1("nognt_req",  obs_req,  1'b1);
      chk ("nognt_addr", obs_addr, 32'h0);
    end
    gnt_en = 1'b1;
    for (int i = 0; i < 5; i++) cycle();

    // Redirect with two slow requests in flight: both responses are dropped.
    do_reset(); lat = 3;
    cycle(); cycle();
    redir = 1'b1; redir_pc = 32'h0000_0100;
    cycle();
    redir = 1'b0; n_deliv = 0;
    for (int i = 0; i < 9; i++) cycle();
    chk("redir_deliveries", n_deliv, 2);
`ifdef IF_PERF_CNT_EN
    chk("redir_flush_cnt", o_flush_cnt, 32'd2);
    chk("redir_flush_model", o_flush_cnt, exp_flush);
    chk("redir_fetch_cnt", o_fetch_cnt, exp_fetch);
`endif

    // Redirect coinciding with a response and a delivery handshake.
    do_reset(); lat = 1;
    for (int i = 0; i < 3; i++) cycle();
    redir = 1'b1; redir_pc = 32'h0000_0203;
    cycle();
    chk1("coinc_valid", obs_valid, 1'b1);
    redir = 1'b0;
    cycle();
    chk1("coinc_next_req",  obs_req,  1'b1);
    chk ("coinc_next_addr", obs_addr, 32'h0000_0200);
`ifdef IF_PERF_CNT_EN
    chk("coinc_fetch_cnt", o_fetch_cnt, 32'd1);
    chk("coinc_flush_cnt", o_flush_cnt, 32'd1);
`endif
    n_deliv = 0;
    for (int i = 0; i < 6; i++) cycle();
    chk("coinc_deliveries", n_deliv, 5);
`ifdef IF_PERF_CNT_EN
    chk("coinc_fetch_model", o_fetch_cnt, exp_fetch);
    chk("coinc_flush_model", o_flush_cnt, exp_flush);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage of the RISC-V core; sits directly upstream of the decode stage.
- Holds the PC and issues word fetches to instruction memory over a req/gnt/rvalid handshake.
- Buffers returned instructions with their PC in a small FIFO and presents them to decode over valid/ready.
- Redirects the PC on taken jal/branch, flushes the buffer and discards stale in-flight responses.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
FIFO_DEPTH, 2, instruction buffer entries (power of two, >=2); also caps outstanding requests

Ports:
i_clk  input  1  clock, all state on rising edge
i_rst_n  input  1  asynchronous active-low reset
i_redirect  input  1  taken jal/branch from downstream; load new PC
i_redirect_pc  input  32  redirect target; bits [1:0] ignored (treated as 0)
o_imem_req  output  1  fetch request valid
o_imem_addr  output  32  fetch word address (bits [1:0] always 0)
i_imem_gnt  input  1  request accepted this cycle (req & gnt)
i_imem_rvalid  input  1  response valid; exactly one per granted request, in order
i_imem_rdata  input  32  fetched instruction word
o_inst_valid  output  1  buffered instruction available to decode
o_inst  output  32  instruction at FIFO head
o_inst_pc  output  32  PC of o_inst
i_inst_ready  input  1  decode accepts head this cycle

Behaviour:
- Reset (async assert, sync deassert handled upstream): pc=RESET_PC, FIFO empty, outstanding=0, drop=0; o_imem_req=0, o_imem_addr=RESET_PC, o_inst_valid=0, o_inst=32'h0000_0013 (NOP), o_inst_pc=0.
- Credit: o_imem_req = !i_redirect && (outstanding + fifo_count < FIFO_DEPTH). FIFO can never overflow.
- o_imem_addr = pc. Address is held stable while req is high and gnt is low.
- On req & gnt: pc <= pc+4, wrapping mod 2^32 (0xFFFF_FFFC -> 0). outstanding++.
- Each granted request pushes its PC into a PC queue (depth FIFO_DEPTH). It is popped when the matching rvalid arrives.
- On rvalid:
  - outstanding--.
  - If drop>0: drop--, data discarded.
  - Otherwise push {rdata, pc} into the FIFO.
- Latency: req/gnt in cycle N, earliest rvalid in N+1, o_inst_valid in N+2. With a 1-cycle memory and ready held high, one instruction per cycle is sustained.
- Output: o_inst_valid = FIFO not empty. o_inst and o_inst_pc show the FIFO head, or NOP/0 when empty. Pop occurs on valid & ready.
- Push and pop in the same cycle while full is legal (occupancy unchanged). This cannot arise past the credit check, but must be handled.
- Redirect (highest priority) in the cycle it is asserted:
  - pc <= {i_redirect_pc[31:2],2'b00}.
  - FIFO and PC queue cleared; pending pop ignored.
  - drop <= outstanding minus (1 if rvalid this cycle).
  - Any rvalid arriving that same cycle is discarded.
  - o_imem_req is low; fetch from the new PC is requested the next cycle.
- Back-to-back redirects: the later one wins. drop accumulates from the live outstanding count; it is never double-counted.
- rvalid with outstanding==0 is a protocol error: ignored, no state change.
- Reset asserted mid-operation clears everything immediately. Memory is required to be reset with it.

Optional Feature:
IF_PERF_CNT_EN
- Defined: adds outputs o_fetch_cnt[31:0] and o_flush_cnt[31:0].
  - o_fetch_cnt counts instructions delivered (valid & ready & !redirect).
  - o_flush_cnt counts responses discarded via drop or same-cycle redirect.
  - Both reset to 0 and wrap.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset release, 1-cycle memory returning rdata=addr, ready=1 -> o_imem_addr 0,4,8,...; o_inst_pc 0,4,8 from cycle 2; one instruction per cycle.
- ready=0 with FIFO_DEPTH=2 -> after 2 responses o_imem_req=0 and pc holds at 8. Raising ready resumes fetch at 8 with no loss or duplication.
- gnt held low 3 cycles -> o_imem_req=1 and o_imem_addr=0 stable all 3 cycles; no pc advance.
- Redirect to 0x100 with 2 requests outstanding (latency 3) -> both responses discarded; next o_inst_pc=0x100 with rdata from 0x100. With macro: flush_cnt=2.
- Redirect to 0x203 coincident with rvalid and valid&ready -> that rvalid dropped, no pop counted; next o_imem_addr=0x200.
- RESET_PC=32'hFFFF_FFF8 -> fetch addresses FFFF_FFF8, FFFF_FFFC, 0000_0000 in order.
